mcm_poll_ctrl: RTL and testbench

MCM_POLL_CTRL -- requirements
Module: mcm_poll_ctrl

---
 rtl/mcm_poll_ctrl.sv | 150 +++++++++++++++
 tb/tb_mcm_poll_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mcm_poll_ctrl.sv
// rtl/mcm_poll_ctrl.sv - round-robin poll controller for four MCM receivers
module mcm_poll_ctrl #(
    parameter int RQ_LEN  = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iTick,
    input  logic [3:0] iEnMask,
    input  logic [3:0] iDone,
    output logic [3:0] oRQ,
    output logic [1:0] oSel,
    output logic       oBusy,
    output logic       oFrameDone,
    output logic [3:0] oTimeoutMask,
    output logic [7:0] oErrCnt,
    output logic       oOverrun
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [3:0]  RQ_LAST  = 4'(RQ_LEN - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  rq_cnt_q, rq_cnt_d;
    logic [3:0]  tmask_q, tmask_d;
    logic [7:0]  err_q, err_d;
    logic        overrun_q, overrun_d;

    // Returns {found, index} of the lowest set bit of m at or above start.
    function automatic logic [2:0] first_from(input logic [3:0] m, input logic [2:0] start);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (!res[2] && m[i] && (3'(i) >= start)) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    logic [2:0] first_en;
    logic [2:0] next_en;
    logic       done_sel;
    logic       tmo_hit;

    always_comb begin
        first_en = first_from(iEnMask, 3'd0);
        next_en  = first_from(mask_q, {1'b0, sel_q} + 3'd1);
        done_sel = iDone[sel_q];
        tmo_hit  = (timer_q == TMO_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sel_q     <= 2'd0;
            mask_q    <= 4'd0;
            timer_q   <= 16'd0;
            rq_cnt_q  <= 4'd0;
            tmask_q   <= 4'd0;
            err_q     <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            mask_q    <= mask_d;
            timer_q   <= timer_d;
            rq_cnt_q  <= rq_cnt_d;
            tmask_q   <= tmask_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (iTick) state_d = (iEnMask == 4'd0) ? S_DONE : S_REQ;
            S_REQ:  if (rq_cnt_q == RQ_LAST) state_d = S_WAIT;
            S_WAIT: if (done_sel || tmo_hit) state_d = S_NEXT;
            S_NEXT: state_d = next_en[2] ? S_REQ : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel_d     = sel_q;
        mask_d    = mask_q;
        timer_d   = timer_q;
        rq_cnt_d  = rq_cnt_q;
        tmask_d   = tmask_q;
        err_d     = err_q;
        overrun_d = iTick && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (iTick) begin
                    mask_d   = iEnMask;
                    tmask_d  = 4'd0;
                    rq_cnt_d = 4'd0;
                    if (first_en[2]) sel_d = first_en[1:0];
                end
            end
            S_REQ: begin
                if (rq_cnt_q == RQ_LAST) begin
                    rq_cnt_d = 4'd0;
                    timer_d  = 16'd0;
                end else begin
                    rq_cnt_d = rq_cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                // Timer parks at its last value so it can never wrap.
                if (!tmo_hit) timer_d = timer_q + 16'd1;
                if (!done_sel && tmo_hit) begin
                    tmask_d[sel_q] = 1'b1;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end
            S_NEXT: begin
                rq_cnt_d = 4'd0;
                if (next_en[2]) sel_d = next_en[1:0];
            end
            default: ;
        endcase
    end

    // Request is decoded from state so an async reset drops it at once.
    always_comb begin
        oRQ          = (state_q == S_REQ) ? (4'b0001 << sel_q) : 4'b0000;
        oSel         = sel_q;
        oBusy        = (state_q != S_IDLE);
        oFrameDone   = (state_q == S_DONE);
        oTimeoutMask = tmask_q;
        oErrCnt      = err_q;
        oOverrun     = overrun_q;
    end

endmodule

// File: tb/tb_mcm_poll_ctrl.sv
// tb/tb_mcm_poll_ctrl.sv - directed self-checking bench for mcm_poll_ctrl
module tb_mcm_poll_ctrl;

    localparam int RQ_LEN  = 4;
    localparam int TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iTick = 1'b0;
    logic [3:0] iEnMask = 4'd0;
    logic [3:0] iDone = 4'd0;
    logic [3:0] oRQ;
    logic [1:0] oSel;
    logic       oBusy;
    logic       oFrameDone;
    logic [3:0] oTimeoutMask;
    logic [7:0] oErrCnt;
    logic       oOverrun;

    mcm_poll_ctrl #(.RQ_LEN(RQ_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .iTick(iTick), .iEnMask(iEnMask), .iDone(iDone),
        .oRQ(oRQ), .oSel(oSel), .oBusy(oBusy), .oFrameDone(oFrameDone),
        .oTimeoutMask(oTimeoutMask), .oErrCnt(oErrCnt), .oOverrun(oOverrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int p_val[8];
    int p_w[8];
    int p_gap[8];
    int np, fd_cnt, fd_at, ov_cnt;
    bit hit_abort, budget_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame; iDone[ch] rises on the dly[ch]-th cycle after its request
    // falls (0 = never). Records request pulses, widths and the gap after each.
    task automatic run_frame(input logic [3:0] mask, input int d0, input int d1,
                             input int d2, input int d3, input logic [3:0] extra,
                             input int ov_ch, input logic [3:0] abort_rq);
        int dly[4];
        logic [3:0] prev_rq;
        int gap, cur, post;
        bit in_gap;
        dly = '{d0, d1, d2, d3};
        prev_rq = 4'd0; gap = 0; cur = 0; post = -1; in_gap = 0;
        np = 0; fd_cnt = 0; fd_at = -1; ov_cnt = 0; hit_abort = 0; budget_out = 0;
        for (int i = 0; i < 8; i++) begin p_val[i] = 0; p_w[i] = 0; p_gap[i] = 0; end
        iDone = extra;
        @(negedge clk); iEnMask = mask; iTick = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            iTick = 1'b0;
            if (oOverrun) ov_cnt++;
            if (abort_rq != 4'd0 && oRQ == abort_rq) begin hit_abort = 1; return; end
            if (oRQ != 4'd0) begin
                if (in_gap) begin p_gap[np-1] = gap; in_gap = 0; end
                if (oRQ != prev_rq) begin
                    if (np < 8) begin p_val[np] = int'(oRQ); p_w[np] = 1; np++; end
                end else if (np > 0) p_w[np-1]++;
                cur = int'(oSel);
                iDone = extra;
            end else if (oFrameDone) begin
                fd_cnt++;
                if (fd_at < 0) fd_at = c;
                if (in_gap) begin p_gap[np-1] = gap; in_gap = 0; end
                iDone = extra;
                if (post < 0) post = 0;
            end else if (oBusy) begin
                if (prev_rq != 4'd0) begin in_gap = 1; gap = 0; end
                if (in_gap) begin
                    gap++;
                    if (dly[cur] != 0 && gap == dly[cur]) iDone[cur[1:0]] = 1'b1;
                    if (cur == ov_ch && gap == 3) begin iTick = 1'b1; iEnMask = 4'd0; end
                end
            end
            prev_rq = oRQ;
            if (post >= 0) begin
                post++;
                if (post > 6) return;
            end
        end
        budget_out = 1;
    endtask

    initial begin
        // Reset values
        #2 reset = 1'b0;
        #1;
        chk("rst_rq", oRQ, 4'd0);
        chk("rst_sel", oSel, 2'd0);
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_fd", oFrameDone, 1'b0);
        chk("rst_tmask", oTimeoutMask, 4'd0);
        chk("rst_err", oErrCnt, 8'd0);
        chk("rst_ov", oOverrun, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // All four channels answer 10 cycles after request
        run_frame(4'b1111, 10, 10, 10, 10, 4'd0, 9, 4'd0);
        chk("a_budget", budget_out, 0);
        chk("a_np", np, 4);
        chk("a_v0", p_val[0], 4'b0001);
        chk("a_v1", p_val[1], 4'b0010);
        chk("a_v2", p_val[2], 4'b0100);
        chk("a_v3", p_val[3], 4'b1000);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("a_w%0d", i), p_w[i], RQ_LEN);
            chk($sformatf("a_gap%0d", i), p_gap[i], 11);
        end
        chk("a_fd", fd_cnt, 1);
        chk("a_tmask", oTimeoutMask, 4'd0);
        chk("a_err", oErrCnt, 8'd0);
        chk("a_sel", oSel, 2'd3);
        chk("a_busy", oBusy, 1'b0);

        // Channel 2 never answers; stray iDone on unpolled channels 1 and 3
        run_frame(4'b0101, 5, 0, 0, 0, 4'b1010, 9, 4'd0);
        chk("b_budget", budget_out, 0);
        chk("b_np", np, 2);
        chk("b_v0", p_val[0], 4'b0001);
        chk("b_v1", p_val[1], 4'b0100);
        chk("b_w1", p_w[1], RQ_LEN);
        chk("b_gap0", p_gap[0], 6);
        chk("b_gap1", p_gap[1], TIMEOUT + 1);
        chk("b_fd", fd_cnt, 1);
        chk("b_tmask", oTimeoutMask, 4'b0100);
        chk("b_err", oErrCnt, 8'd1);
        chk("b_sel", oSel, 2'd2);

        // Empty mask: straight to DONE, timeout mask cleared
        run_frame(4'b0000, 0, 0, 0, 0, 4'd0, 9, 4'd0);
        chk("c_budget", budget_out, 0);
        chk("c_np", np, 0);
        chk("c_fd", fd_cnt, 1);
        chk("c_fd_at", fd_at, 0);
        chk("c_tmask", oTimeoutMask, 4'd0);
        chk("c_err", oErrCnt, 8'd1);

        // Tick plus mask change while waiting on channel 1
        run_frame(4'b1011, 4, 4, 4, 4, 4'd0, 1, 4'd0);
        chk("d_budget", budget_out, 0);
        chk("d_np", np, 3);
        chk("d_v0", p_val[0], 4'b0001);
        chk("d_v1", p_val[1], 4'b0010);
        chk("d_v2", p_val[2], 4'b1000);
        chk("d_gap2", p_gap[2], 5);
        chk("d_ov", ov_cnt, 1);
        chk("d_fd", fd_cnt, 1);
        chk("d_busy", oBusy, 1'b0);
        chk("d_err", oErrCnt, 8'd1);

        // Done arrives on the last timer cycle: done wins
        run_frame(4'b0100, 0, 0, TIMEOUT, 0, 4'd0, 9, 4'd0);
        chk("e_budget", budget_out, 0);
        chk("e_np", np, 1);
        chk("e_gap", p_gap[0], TIMEOUT + 1);
        chk("e_tmask", oTimeoutMask, 4'd0);
        chk("e_err", oErrCnt, 8'd1);

        // Reset during channel 3 request
        run_frame(4'b1111, 3, 3, 3, 3, 4'd0, 9, 4'b1000);
        chk("f_abort", hit_abort, 1);
        #2 reset = 1'b0;
        #1;
        chk("f_rq", oRQ, 4'd0);
        chk("f_sel", oSel, 2'd0);
        chk("f_busy", oBusy, 1'b0);
        chk("f_fd", oFrameDone, 1'b0);
        chk("f_err", oErrCnt, 8'd0);
        chk("f_ov", oOverrun, 1'b0);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("f_idle", oBusy, 1'b0);
        run_frame(4'b1111, 3, 3, 3, 3, 4'd0, 9, 4'd0);
        chk("g_budget", budget_out, 0);
        chk("g_np", np, 4);
        chk("g_v3", p_val[3], 4'b1000);
        chk("g_w3", p_w[3], RQ_LEN);
        chk("g_gap0", p_gap[0], 4);
        chk("g_fd", fd_cnt, 1);
        chk("g_err", oErrCnt, 8'd0);

        // 300 forced timeouts: counter saturates
        for (int f = 0; f < 63; f++) run_frame(4'b1111, 0, 0, 0, 0, 4'd0, 9, 4'd0);
        chk("h_budget", budget_out, 0);
        chk("h_err252", oErrCnt, 8'd252);
        chk("h_tmask", oTimeoutMask, 4'b1111);
        for (int f = 0; f < 12; f++) run_frame(4'b1111, 0, 0, 0, 0, 4'd0, 9, 4'd0);
        chk("h_err255", oErrCnt, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
